// File: rtl/instr_encode_loader_pkg.sv
// Shared types for the RV32I instruction encode/loader: opcodes, error codes,
// loader states, packer field tuple and per-format immediate ranges.
package instr_encode_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  typedef enum logic [OPC_W-1:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef logic signed [WORD_W-1:0] imm_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_OPCODE = 2'd1,
    ERR_IMM    = 2'd2,
    ERR_FULL   = 2'd3
  } enc_err_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

  // Decoded field tuple as presented to the packer
  typedef struct packed {
    opcode_t          opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    imm_t             imm;
  } enc_fields_t;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Tuple stream, instruction-memory write port and status of the loader.
interface instr_encode_loader_if
  import instr_encode_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) ();

  logic              start;
  logic              in_valid;
  logic              in_ready;
  opcode_t           in_opcode;
  logic [REG_W-1:0]  in_rd;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [F3_W-1:0]   in_funct3;
  logic [F7_W-1:0]   in_funct7;
  imm_t              in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err;
  enc_err_t          err_code;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, word_count
  );

  modport slave (
    input  start, in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, word_count
  );

endinterface

// File: rtl/instr_encode_loader_field_packer.sv
// Combinational RV32I field tuple -> 32-bit instruction word plus legality code.
module instr_field_packer
  import instr_encode_loader_pkg::*;
(
  input  enc_fields_t        fields,
  output logic [WORD_W-1:0]  word_c,
  output enc_err_t           err_c
);

  always_comb begin
    word_c = '0;
    err_c  = ERR_NONE;
    case (fields.opcode)
      OPC_OP: begin
        word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
        word_c = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        if (fields.imm < IMM_I_MIN || fields.imm > IMM_I_MAX) err_c = ERR_IMM;
      end
      OPC_STORE: begin
        word_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3, fields.imm[4:0],
                  fields.opcode};
        if (fields.imm < IMM_I_MIN || fields.imm > IMM_I_MAX) err_c = ERR_IMM;
      end
      OPC_BRANCH: begin
        word_c = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                  fields.imm[4:1], fields.imm[11], fields.opcode};
        if (fields.imm < IMM_B_MIN || fields.imm > IMM_B_MAX || fields.imm[0]) err_c = ERR_IMM;
      end
      OPC_LUI, OPC_AUIPC: begin
        word_c = {fields.imm[31:12], fields.rd, fields.opcode};
        if (fields.imm[11:0] != 12'h000) err_c = ERR_IMM;
      end
      OPC_JAL: begin
        word_c = {fields.imm[20], fields.imm[10:1], fields.imm[11], fields.imm[19:12],
                  fields.rd, fields.opcode};
        if (fields.imm < IMM_J_MIN || fields.imm > IMM_J_MAX || fields.imm[0]) err_c = ERR_IMM;
      end
      default: err_c = ERR_OPCODE;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts decoded RV32I tuples, encodes them and writes them sequentially into
// instruction memory, tracking address, write count and load errors.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_encode_loader_if.slave bus
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  loader_state_t     state_q, state_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [WORD_W-1:0] wdata_q, wdata_n;
  logic [CNT_W-1:0]  count_q, count_n;
  enc_err_t          err_code_q, err_code_n;
  logic              full_q, full_n;
  logic              last_q, last_n;
  logic              busy_q, done_q, err_q;

  enc_fields_t       fields;
  logic [WORD_W-1:0] word_c;
  enc_err_t          pack_err_c;
  logic              in_ready_c;
  logic              accept_c;
  logic              write_done_c;
  logic              full_c;

  assign fields = '{opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2,
                    funct3: bus.in_funct3, funct7: bus.in_funct7, imm: bus.in_imm};

  instr_field_packer u_packer (
    .fields (fields),
    .word_c (word_c),
    .err_c  (pack_err_c)
  );

  assign in_ready_c   = (state_q == ST_LOAD) && (!we_q || bus.mem_ready);
  assign accept_c     = bus.in_valid && in_ready_c;
  assign write_done_c = we_q && bus.mem_ready;
  // Full also covers the top address completing in the same cycle as the next accept
  assign full_c       = full_q || (write_done_c && addr_q == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    we_n       = we_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    count_n    = count_q;
    err_code_n = err_code_q;
    full_n     = full_q;
    last_n     = last_q;
    if (bus.start) begin
      // start wins over everything and drops any pending write
      state_n    = ST_LOAD;
      we_n       = 1'b0;
      addr_n     = BASE;
      count_n    = '0;
      err_code_n = ERR_NONE;
      full_n     = 1'b0;
      last_n     = 1'b0;
    end else if (state_q == ST_LOAD) begin
      if (write_done_c) begin
        we_n    = 1'b0;
        addr_n  = addr_q + ADDR_W'(1);
        count_n = count_q + CNT_W'(1);
        last_n  = 1'b0;
        if (addr_q == LAST_ADDR) full_n = 1'b1;
        if (last_q) state_n = ST_DONE;
      end
      if (accept_c) begin
        if (pack_err_c != ERR_NONE) begin
          err_code_n = pack_err_c;
          state_n    = ST_ERROR;
        end else if (full_c) begin
          err_code_n = ERR_FULL;
          state_n    = ST_ERROR;
        end else begin
          we_n    = 1'b1;
          wdata_n = word_c;
          last_n  = bus.in_last;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= '0;
      count_q    <= '0;
      err_code_q <= ERR_NONE;
      full_q     <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q       <= we_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      count_q    <= count_n;
      err_code_q <= err_code_n;
      full_q     <= full_n;
      last_q     <= last_n;
      busy_q     <= (state_n == ST_LOAD);
      done_q     <= (state_n == ST_DONE);
      err_q      <= (state_n == ST_ERROR);
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.word_count = count_q;
  assign bus.err_code   = err_code_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader (ADDR_W=10 main, ADDR_W=2 for full).
module tb_instr_encode_loader;
  import instr_encode_loader_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  int   cyc;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  int  s_addrs[$];

  localparam logic [31:0] EXP_W [5] = '{32'h002081B3, 32'h0020A223, 32'h00208463,
                                        32'h123452B7, 32'h001000EF};

  instr_encode_loader_if #(.ADDR_W(10)) m ();
  instr_encode_loader_if #(.ADDR_W(2))  s ();

  instr_encode_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Completed-write monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m.mem_we === 1'b1 && m.mem_ready === 1'b1) begin
      wr_t w;
      w.addr = int'(m.mem_addr);
      w.data = m.mem_wdata;
      w.cyc  = cyc;
      wq.push_back(w);
    end
    if (rst_n === 1'b1 && s.mem_we === 1'b1 && s.mem_ready === 1'b1)
      s_addrs.push_back(int'(s.mem_addr));
  end

  task automatic pulse_start_main();
    @(posedge clk); #1 m.start = 1'b1;
    @(posedge clk); #1 m.start = 1'b0;
  endtask

  task automatic send_main(input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input int imm, input logic last);
    int n;
    bit ok;
    m.in_opcode = op;  m.in_rd = rd;  m.in_rs1 = rs1;  m.in_rs2 = rs2;
    m.in_funct3 = f3;  m.in_funct7 = f7;  m.in_imm = imm;  m.in_last = last;
    m.in_valid  = 1'b1;
    n = 0; ok = 1'b0;
    while (n < 64 && !ok) begin
      @(negedge clk);
      if (m.in_ready === 1'b1) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: in_ready got 0 for 64 cycles, expected 1");
    end
    @(posedge clk); #1 m.in_valid = 1'b0;
  endtask

  task automatic wait_main_end();
    int n;
    n = 0;
    while (n < 64 && m.done !== 1'b1 && m.err !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m.done !== 1'b1 && m.err !== 1'b1)
      $display("FAIL end_timeout: done/err got 0/0, expected a terminal state");
    else passed++;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (m.mem_we !== 1'b0) $display("FAIL rst_we got %b exp 0", m.mem_we); else passed++;
    checks++; if (m.mem_addr !== 10'd0) $display("FAIL rst_addr got %0d exp 0", m.mem_addr); else passed++;
    checks++; if (m.mem_wdata !== 32'h0) $display("FAIL rst_wdata got %h exp 0", m.mem_wdata); else passed++;
    checks++; if (m.word_count !== 11'd0) $display("FAIL rst_count got %0d exp 0", m.word_count); else passed++;
    checks++; if (m.err_code !== ERR_NONE) $display("FAIL rst_err_code got %0d exp 0", m.err_code); else passed++;
    checks++;
    if ({m.in_ready, m.busy, m.done, m.err} !== 4'b0000)
      $display("FAIL rst_flags got %b exp 0000", {m.in_ready, m.busy, m.done, m.err});
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (m.in_ready !== 1'b0) $display("FAIL idle_ready got %b exp 0", m.in_ready); else passed++;
  endtask

  task automatic test_single();
    pulse_start_main();
    wq.delete();
    checks++; if (m.busy !== 1'b1) $display("FAIL t1_busy got %b exp 1", m.busy); else passed++;
    send_main(OPC_OP_IMM, 5'd1, 5'd0, 5'd7, 3'd0, 7'h55, 5, 1'b1);
    checks++; if (m.mem_we !== 1'b1) $display("FAIL t1_we got %b exp 1", m.mem_we); else passed++;
    checks++; if (m.mem_addr !== 10'd0) $display("FAIL t1_addr got %0d exp 0", m.mem_addr); else passed++;
    checks++; if (m.mem_wdata !== 32'h00500093) $display("FAIL t1_wdata got %h exp 00500093", m.mem_wdata); else passed++;
    @(posedge clk); #1;
    checks++; if (m.done !== 1'b1 || m.busy !== 1'b0) $display("FAIL t1_done got done=%b busy=%b exp 1/0", m.done, m.busy); else passed++;
    checks++; if (m.word_count !== 11'd1) $display("FAIL t1_count got %0d exp 1", m.word_count); else passed++;
    checks++; if (m.mem_we !== 1'b0) $display("FAIL t1_we_off got %b exp 0", m.mem_we); else passed++;
  endtask

  task automatic test_back_to_back();
    pulse_start_main();
    wq.delete();
    send_main(OPC_OP,     5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h7FF, 1'b0);
    send_main(OPC_STORE,  5'd31, 5'd1,  5'd2,  3'd2, 7'h7F, 4, 1'b0);
    send_main(OPC_BRANCH, 5'd9,  5'd1,  5'd2,  3'd0, 7'h7F, 8, 1'b0);
    send_main(OPC_LUI,    5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h12345000, 1'b0);
    send_main(OPC_JAL,    5'd1,  5'd3,  5'd3,  3'd5, 7'h01, 2048, 1'b1);
    wait_main_end();
    checks++; if (wq.size() != 5) $display("FAIL t2_nwrites got %0d exp 5", wq.size()); else passed++;
    for (int i = 0; i < wq.size() && i < 5; i++) begin
      checks++;
      if (wq[i].addr != i || wq[i].data !== EXP_W[i] || wq[i].cyc != wq[0].cyc + i)
        $display("FAIL t2_word%0d got addr=%0d data=%h cyc+%0d exp addr=%0d data=%h cyc+%0d",
                 i, wq[i].addr, wq[i].data, wq[i].cyc - wq[0].cyc, i, EXP_W[i], i);
      else passed++;
    end
    checks++; if (m.word_count !== 11'd5 || m.done !== 1'b1) $display("FAIL t2_count got %0d done=%b exp 5/1", m.word_count, m.done); else passed++;
  endtask

  task automatic test_backpressure();
    logic [9:0]  cap_addr;
    logic [31:0] cap_data;
    pulse_start_main();
    wq.delete();
    fork
      begin
        send_main(OPC_OP,     5'd3, 5'd1,  5'd2,  3'd0, 7'h00, 0, 1'b0);
        send_main(OPC_STORE,  5'd0, 5'd1,  5'd2,  3'd2, 7'h00, 4, 1'b0);
        send_main(OPC_BRANCH, 5'd0, 5'd1,  5'd2,  3'd0, 7'h00, 8, 1'b0);
        send_main(OPC_LUI,    5'd5, 5'd0,  5'd0,  3'd0, 7'h00, 32'h12345000, 1'b1);
      end
      begin
        @(posedge clk); #1 m.mem_ready = 1'b0;
        @(negedge clk);
        cap_addr = m.mem_addr;
        cap_data = m.mem_wdata;
        checks++; if (m.mem_we !== 1'b1 || m.in_ready !== 1'b0) $display("FAIL t3_stall0 got we=%b ready=%b exp 1/0", m.mem_we, m.in_ready); else passed++;
        repeat (2) begin
          @(negedge clk);
          checks++;
          if (m.in_ready !== 1'b0 || m.mem_addr !== cap_addr || m.mem_wdata !== cap_data)
            $display("FAIL t3_hold got ready=%b addr=%0d data=%h exp 0/%0d/%h",
                     m.in_ready, m.mem_addr, m.mem_wdata, cap_addr, cap_data);
          else passed++;
        end
        @(posedge clk); #1 m.mem_ready = 1'b1;
      end
    join
    wait_main_end();
    checks++; if (wq.size() != 4) $display("FAIL t3_nwrites got %0d exp 4", wq.size()); else passed++;
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      checks++;
      if (wq[i].addr != i || wq[i].data !== EXP_W[i])
        $display("FAIL t3_word%0d got addr=%0d data=%h exp addr=%0d data=%h", i, wq[i].addr, wq[i].data, i, EXP_W[i]);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    pulse_start_main();
    wq.delete();
    send_main(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 2048, 1'b0);
    checks++; if (m.err !== 1'b1 || m.err_code !== ERR_IMM) $display("FAIL t4_addi_err got err=%b code=%0d exp 1/2", m.err, m.err_code); else passed++;
    checks++; if (m.mem_we !== 1'b0 || m.busy !== 1'b0 || m.in_ready !== 1'b0) $display("FAIL t4_addi_idle got we=%b busy=%b ready=%b exp 000", m.mem_we, m.busy, m.in_ready); else passed++;
    @(posedge clk); #1;
    checks++; if (wq.size() != 0) $display("FAIL t4_nowrite got %0d writes exp 0", wq.size()); else passed++;
    pulse_start_main();
    checks++; if (m.busy !== 1'b1 || m.err !== 1'b0 || m.err_code !== ERR_NONE) $display("FAIL t4_restart got busy=%b err=%b code=%0d exp 1/0/0", m.busy, m.err, m.err_code); else passed++;
    send_main(OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, -2048, 1'b0);
    send_main(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 7, 1'b0);
    checks++; if (m.err_code !== ERR_IMM || m.word_count !== 11'd1) $display("FAIL t4_beq got code=%0d count=%0d exp 2/1", m.err_code, m.word_count); else passed++;
    checks++; if (wq.size() != 1 || wq[0].data !== 32'h80000113) $display("FAIL t4_neg_addi got n=%0d exp 1 word 80000113", wq.size()); else passed++;
    pulse_start_main();
    checks++; if (m.word_count !== 11'd0 || m.mem_addr !== 10'd0 || m.busy !== 1'b1) $display("FAIL t4_clear got count=%0d addr=%0d busy=%b exp 0/0/1", m.word_count, m.mem_addr, m.busy); else passed++;
    send_main(opcode_t'(7'h7F), 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 5000, 1'b0);
    checks++; if (m.err_code !== ERR_OPCODE || m.err !== 1'b1) $display("FAIL t4_opcode got code=%0d err=%b exp 1/1", m.err_code, m.err); else passed++;
  endtask

  task automatic test_full();
    @(posedge clk); #1 s.start = 1'b1;
    @(posedge clk); #1 s.start = 1'b0;
    s_addrs.delete();
    for (int k = 0; k < 5; k++) begin
      int n;
      n = 0;
      s.in_opcode = OPC_OP_IMM; s.in_rd = 5'd1; s.in_rs1 = 5'd0; s.in_rs2 = 5'd0;
      s.in_funct3 = 3'd0; s.in_funct7 = 7'h00; s.in_imm = k; s.in_last = 1'b0;
      s.in_valid = 1'b1;
      while (n < 64 && s.in_ready !== 1'b1) begin @(negedge clk); n++; end
      if (s.in_ready !== 1'b1) begin checks++; $display("FAIL t5_accept_timeout tuple %0d got ready=0 exp 1", k); end
      @(posedge clk); #1 s.in_valid = 1'b0;
    end
    checks++; if (s.err !== 1'b1 || s.err_code !== ERR_FULL) $display("FAIL t5_full got err=%b code=%0d exp 1/3", s.err, s.err_code); else passed++;
    checks++; if (s.word_count !== 3'd4) $display("FAIL t5_count got %0d exp 4", s.word_count); else passed++;
    @(posedge clk); #1;
    checks++; if (s_addrs.size() != 4 || s.mem_we !== 1'b0) $display("FAIL t5_nwrites got %0d we=%b exp 4/0", s_addrs.size(), s.mem_we); else passed++;
    for (int i = 0; i < s_addrs.size() && i < 4; i++) begin
      checks++; if (s_addrs[i] != i) $display("FAIL t5_addr%0d got %0d exp %0d", i, s_addrs[i], i); else passed++;
    end
  endtask

  task automatic test_abort();
    pulse_start_main();
    wq.delete();
    send_main(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 1, 1'b0);
    send_main(OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 2, 1'b0);
    m.mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (m.mem_we !== 1'b1 || m.mem_addr !== 10'd1) $display("FAIL t6_held got we=%b addr=%0d exp 1/1", m.mem_we, m.mem_addr); else passed++;
    pulse_start_main();
    checks++; if (m.mem_we !== 1'b0 || m.mem_addr !== 10'd0 || m.word_count !== 11'd0) $display("FAIL t6_start got we=%b addr=%0d count=%0d exp 0/0/0", m.mem_we, m.mem_addr, m.word_count); else passed++;
    checks++; if (wq.size() != 1) $display("FAIL t6_dropped got %0d writes exp 1", wq.size()); else passed++;
    m.mem_ready = 1'b1;
    send_main(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 1, 1'b0);
    send_main(OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 2, 1'b0);
    m.mem_ready = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if (m.mem_we !== 1'b0 || m.mem_addr !== 10'd0 || m.mem_wdata !== 32'h0) $display("FAIL t6_rst_mem got we=%b addr=%0d data=%h exp 0/0/0", m.mem_we, m.mem_addr, m.mem_wdata); else passed++;
    checks++; if (m.word_count !== 11'd0 || m.err_code !== ERR_NONE) $display("FAIL t6_rst_cnt got count=%0d code=%0d exp 0/0", m.word_count, m.err_code); else passed++;
    checks++;
    if ({m.in_ready, m.busy, m.done, m.err} !== 4'b0000)
      $display("FAIL t6_rst_flags got %b exp 0000", {m.in_ready, m.busy, m.done, m.err});
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    m.mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; passed = 0; cyc = 0;
    rst_n = 1'b0;
    m.start = 1'b0; m.in_valid = 1'b0; m.in_opcode = OPC_OP; m.in_rd = '0; m.in_rs1 = '0;
    m.in_rs2 = '0; m.in_funct3 = '0; m.in_funct7 = '0; m.in_imm = '0; m.in_last = 1'b0;
    m.mem_ready = 1'b1;
    s.start = 1'b0; s.in_valid = 1'b0; s.in_opcode = OPC_OP; s.in_rd = '0; s.in_rs1 = '0;
    s.in_rs2 = '0; s.in_funct3 = '0; s.in_funct7 = '0; s.in_imm = '0; s.in_last = 1'b0;
    s.mem_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_full();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
